// File: rtl/music_seq_pkg.sv
// Shared types and constants for the music sequencer: FSM states, ROM entry
// layout and tempo encodings.
package music_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_PAUSED,
    ST_DONE
  } seq_state_t;

  localparam int BEATS_W          = 4;
  localparam int DEFAULT_PERIOD_W = 24;
  localparam logic [BEATS_W-1:0] END_BEATS = '0;

  localparam logic [1:0] TEMPO_SLOW    = 2'b00;
  localparam logic [1:0] TEMPO_NORMAL  = 2'b01;
  localparam logic [1:0] TEMPO_FAST    = 2'b10;
  localparam logic [1:0] TEMPO_FASTEST = 2'b11;

  function automatic int entry_width(input int period_w);
    return period_w + BEATS_W;
  endfunction

endpackage

// File: rtl/music_rom.sv
// Note ROM of {period, beats} entries with a registered (1-cycle) read.
// TEST_SONG selects a short phrase instead of the production song.
module music_rom
  import music_seq_pkg::*;
#(
  parameter int ROM_DEPTH = 32,
  parameter int PERIOD_W  = DEFAULT_PERIOD_W,
  parameter bit TEST_SONG = 1'b0,
  localparam int ADDR_W   = $clog2(ROM_DEPTH),
  localparam int ENTRY_W  = entry_width(PERIOD_W)
) (
  input  logic               clk,
  input  logic [ADDR_W-1:0]  addr,
  output logic [ENTRY_W-1:0] data
);

  logic [ENTRY_W-1:0] word;

  function automatic logic [ENTRY_W-1:0] entry(input int period, input int beats);
    return {PERIOD_W'(period), BEATS_W'(beats)};
  endfunction

  // Unlisted addresses decode to zero, i.e. the end-of-song marker.
  always_comb begin
    word = '0;
    if (TEST_SONG) begin
      case (addr)
        ADDR_W'(0): word = entry(100, 1);
        ADDR_W'(1): word = entry(0, 2);
        ADDR_W'(2): word = entry(200, 1);
        default:    word = '0;
      endcase
    end else begin
      case (addr)
        ADDR_W'(0):  word = entry(63073, 1);  // C4
        ADDR_W'(1):  word = entry(63073, 1);
        ADDR_W'(2):  word = entry(42092, 1);  // G4
        ADDR_W'(3):  word = entry(42092, 1);
        ADDR_W'(4):  word = entry(37500, 1);  // A4
        ADDR_W'(5):  word = entry(37500, 1);
        ADDR_W'(6):  word = entry(42092, 2);
        ADDR_W'(7):  word = entry(47250, 1);  // F4
        ADDR_W'(8):  word = entry(47250, 1);
        ADDR_W'(9):  word = entry(50060, 1);  // E4
        ADDR_W'(10): word = entry(50060, 1);
        ADDR_W'(11): word = entry(56180, 1);  // D4
        ADDR_W'(12): word = entry(56180, 1);
        ADDR_W'(13): word = entry(63073, 2);
        ADDR_W'(14): word = entry(0, 2);      // closing rest
        default:     word = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    data <= word;
  end

endmodule

// File: rtl/music_sequencer.sv
// Steps through the note ROM and drives the tone generator's period/enable.
// Define MUSIC_SEQ_GAP_EN for a silent gap between notes (staccato); otherwise legato.
module music_sequencer
  import music_seq_pkg::*;
#(
  parameter int BEAT_CYCLES = 8_250_000,
  parameter int GAP_CYCLES  = 330_000,
  parameter int ROM_DEPTH   = 32,
  parameter int PERIOD_W    = DEFAULT_PERIOD_W,
  parameter bit TEST_SONG   = 1'b0,
  localparam int ADDR_W     = $clog2(ROM_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                pause,
  input  logic                stop,
  input  logic                loop_en,
  input  logic [1:0]          tempo,
  output logic [PERIOD_W-1:0] tone_period,
  output logic                tone_enable,
  output logic [ADDR_W-1:0]   note_index,
  output logic                busy,
  output logic                done
);

  localparam int ENTRY_W = entry_width(PERIOD_W);
  localparam int DUR_W   = $clog2(15 * 2 * BEAT_CYCLES);

  // The fastest tempo needs at least one cycle per beat, and a gap of at least one cycle.
  if (BEAT_CYCLES < 4 || GAP_CYCLES < 1) begin : g_bad_cfg
    $error("music_sequencer: BEAT_CYCLES must be >= 4 and GAP_CYCLES >= 1");
  end

  seq_state_t          state_reg, state_next, saved_reg, saved_next, step_state;
  logic [DUR_W-1:0]    dur_cnt_reg, dur_cnt_next, step_dur;
  logic [ADDR_W-1:0]   addr_reg, addr_next, step_addr;
  logic [PERIOD_W-1:0] period_reg, period_next, step_period;
  logic                enable_reg, enable_next, step_enable;
  logic [ENTRY_W-1:0]  rom_data;
  logic [PERIOD_W-1:0] rom_period;
  logic [BEATS_W-1:0]  rom_beats;
  logic [DUR_W-1:0]    beat_len, note_cycles;
`ifdef MUSIC_SEQ_GAP_EN
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  logic [GAP_W-1:0]    gap_cnt_reg, gap_cnt_next, step_gap;
`endif

  music_rom #(
    .ROM_DEPTH (ROM_DEPTH),
    .PERIOD_W  (PERIOD_W),
    .TEST_SONG (TEST_SONG)
  ) u_rom (
    .clk  (clk),
    .addr (addr_reg),
    .data (rom_data)
  );

  assign rom_period = rom_data[ENTRY_W-1:BEATS_W];
  assign rom_beats  = rom_data[BEATS_W-1:0];

  always_comb begin
    case (tempo)
      TEMPO_SLOW:   beat_len = DUR_W'(2 * BEAT_CYCLES);
      TEMPO_NORMAL: beat_len = DUR_W'(BEAT_CYCLES);
      TEMPO_FAST:   beat_len = DUR_W'(BEAT_CYCLES / 2);
      default:      beat_len = DUR_W'(BEAT_CYCLES / 4);
    endcase
  end

  assign note_cycles = DUR_W'(rom_beats) * beat_len;

  // step_* is what the running state would do this edge; pause/stop/start then
  // decide whether that step is taken, deferred behind PAUSED, or overridden.
  always_comb begin
    step_state  = state_reg;
    step_dur    = dur_cnt_reg;
    step_addr   = addr_reg;
    step_period = period_reg;
    step_enable = enable_reg;
`ifdef MUSIC_SEQ_GAP_EN
    step_gap    = gap_cnt_reg;
`endif
    case (state_reg)
      ST_FETCH: step_state = ST_LOAD;
      ST_LOAD: begin
        if (rom_beats == END_BEATS) begin
          if (loop_en) begin
            step_addr  = '0;
            step_state = ST_FETCH;
          end else begin
            step_state = ST_DONE;
          end
        end else begin
          step_period = rom_period;
          step_enable = (rom_period != '0);
          step_dur    = note_cycles - 1'b1;
          step_state  = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (dur_cnt_reg == '0) begin
`ifdef MUSIC_SEQ_GAP_EN
          step_enable = 1'b0;
          step_gap    = GAP_W'(GAP_CYCLES - 1);
          step_state  = ST_GAP;
`else
          step_addr   = addr_reg + 1'b1;
          step_state  = ST_FETCH;
`endif
        end else begin
          step_dur = dur_cnt_reg - 1'b1;
        end
      end
`ifdef MUSIC_SEQ_GAP_EN
      ST_GAP: begin
        if (gap_cnt_reg == '0) begin
          step_addr  = addr_reg + 1'b1;
          step_state = ST_FETCH;
        end else begin
          step_gap = gap_cnt_reg - 1'b1;
        end
      end
`endif
      default: ;
    endcase

    state_next   = state_reg;
    saved_next   = saved_reg;
    dur_cnt_next = dur_cnt_reg;
    addr_next    = addr_reg;
    period_next  = period_reg;
    enable_next  = enable_reg;
`ifdef MUSIC_SEQ_GAP_EN
    gap_cnt_next = gap_cnt_reg;
`endif
    if (state_reg == ST_DONE) begin
      state_next  = ST_IDLE;
      period_next = '0;
    end else if (state_reg == ST_IDLE) begin
      if (start) begin
        addr_next  = '0;
        state_next = ST_FETCH;
      end
    end else if (stop) begin
      state_next  = ST_DONE;
      enable_next = 1'b0;
    end else if (state_reg == ST_PAUSED) begin
      if (pause) begin
        state_next  = saved_reg;
        enable_next = (saved_reg == ST_PLAY) && (period_reg != '0);
      end
    end else begin
      // The pulse cycle itself still counts, so a paused note keeps its full length.
      state_next   = step_state;
      dur_cnt_next = step_dur;
      addr_next    = step_addr;
      period_next  = step_period;
      enable_next  = step_enable;
`ifdef MUSIC_SEQ_GAP_EN
      gap_cnt_next = step_gap;
`endif
      if (step_state == ST_DONE) begin
        enable_next = 1'b0;
      end else if (pause) begin
        saved_next  = step_state;
        state_next  = ST_PAUSED;
        enable_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      saved_reg   <= ST_IDLE;
      dur_cnt_reg <= '0;
      addr_reg    <= '0;
      period_reg  <= '0;
      enable_reg  <= 1'b0;
`ifdef MUSIC_SEQ_GAP_EN
      gap_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      saved_reg   <= saved_next;
      dur_cnt_reg <= dur_cnt_next;
      addr_reg    <= addr_next;
      period_reg  <= period_next;
      enable_reg  <= enable_next;
`ifdef MUSIC_SEQ_GAP_EN
      gap_cnt_reg <= gap_cnt_next;
`endif
    end
  end

  assign tone_period = period_reg;
  assign tone_enable = enable_reg;
  assign note_index  = addr_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign done        = (state_reg == ST_DONE);

endmodule

// File: doc/music_sequencer.md
Name: music_sequencer

Overview:
Plays a fixed song on the piezo by sequencing the existing tone generator. It steps through a note ROM; each entry holds a half-period count and a duration in beats. For each note it drives the tone generator's period and enable inputs for the note's duration, then inserts an articulation gap. It sits between the board top level (DIP switches and buttons) and the tone generator.

Parameters:
BEAT_CYCLES, 8_250_000, clock cycles per beat at tempo 01 (0.25 s at 33 MHz)
GAP_CYCLES, 330_000, silent cycles between notes (10 ms)
ROM_DEPTH, 32, number of note entries; address width ADDR_W = clog2(ROM_DEPTH)
PERIOD_W, 24, width of the tone half-period count

Ports:
clk  in  1  system clock (33 MHz)
rst  in  1  asynchronous active-high reset
start  in  1  1-cycle pulse; begins playback from entry 0 when idle
pause  in  1  1-cycle pulse; toggles pause while playing
stop  in  1  1-cycle pulse; aborts playback and returns to idle
loop_en  in  1  level; restart at entry 0 when the end marker is reached
tempo  in  2  beat length: 00 = 2*BEAT_CYCLES, 01 = BEAT_CYCLES, 10 = BEAT_CYCLES/2, 11 = BEAT_CYCLES/4
tone_period  out  PERIOD_W  half-period count for the tone generator
tone_enable  out  1  tone generator output enable
note_index  out  ADDR_W  ROM address of the current note
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse when the song ends without looping, or on stop

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values: state = IDLE, tone_period = 0, tone_enable = 0, note_index = 0, busy = 0, done = 0, all counters 0.
- ROM entry format is {period[PERIOD_W-1:0], beats[3:0]}.
  - beats == 0: end-of-song marker.
  - period == 0: rest; tone_enable stays 0 for the note's duration.
- The ROM is synchronous read with 1-cycle latency.
- States: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED, DONE.
- IDLE: outputs are at reset values except note_index, which holds.
  - A start pulse sets the address to 0 and moves to FETCH on the next edge.
- FETCH: presents the address to the ROM, then moves to LOAD (1 cycle).
- LOAD: captures the ROM data.
  - If beats == 0: go to FETCH at address 0 if loop_en is set, else go to DONE.
  - Otherwise, in the same edge:
    - set tone_period = period and tone_enable = (period != 0);
    - latch beat_len from tempo;
    - load dur_cnt = beats*beat_len - 1;
    - move to PLAY.
  - Start-to-tone latency is 3 edges.
- PLAY: dur_cnt decrements each cycle. At 0, clear tone_enable, load gap_cnt = GAP_CYCLES - 1, and move to GAP.
  - A note is audible for exactly beats*beat_len cycles.
- GAP: gap_cnt decrements each cycle. At 0, increment the address and move to FETCH.
  - The address wraps mod ROM_DEPTH if no marker is present.
- DONE: asserts done for 1 cycle, clears tone_period, returns to IDLE.
- PAUSED:
  - Entered on a pause pulse from FETCH, LOAD, PLAY or GAP.
  - The state being paused is saved, tone_enable forced to 0, and all counters frozen.
  - The next pause pulse restores the saved state and tone_enable = (tone_period != 0) if the saved state was PLAY; counting resumes from the frozen value.
- Priority for simultaneous pulses: stop > pause > start.
  - stop in any busy state: next edge goes to DONE (done pulses), tone_enable = 0.
  - start while busy: ignored.
  - pause in IDLE or DONE: ignored.
- A tempo change affects only notes loaded after the change.
- dur_cnt width is clog2(15*2*BEAT_CYCLES). Multiplication is unsigned and sized to that width, so there is no overflow.

Optional Feature:
MUSIC_SEQ_GAP_EN
- Defined: GAP state behaves as above (staccato articulation).
- Undefined: the GAP state and gap_cnt are not built.
  - When dur_cnt reaches 0 in PLAY, the address increments and the FSM goes to FETCH with tone_enable held.
  - tone_enable then updates at the next LOAD (legato; at most 2 cycles at the old period).
  - GAP_CYCLES is ignored.

Decomposition:
- Package music_seq_pkg:
  - state enum;
  - BEATS_W = 4 and END_BEATS = 0;
  - ROM entry field widths;
  - tempo encoding constants.
- One sub-module, music_rom:
  - synchronous-read case ROM of ROM_DEPTH entries;
  - inputs clk and addr; output data.
- The FSM, counters and pause logic stay in music_sequencer.

Test Plan:
- Bench overrides BEAT_CYCLES = 8, GAP_CYCLES = 2; ROM = {(100,1), (0,2), (200,1), (x,0)}.
- Basic song, loop_en = 0, tempo = 01, start pulse at cycle 0:
  - tone_enable rises at edge 3 with tone_period = 100 and stays high for 8 cycles;
  - 2 gap cycles, then rest for 16 cycles with tone_enable = 0 and tone_period = 0;
  - then period 200 for 8 cycles;
  - done pulses once; busy falls.
- Loop: same as above with loop_en = 1. After the last note, note_index returns to 0 and period 100 replays; done never pulses.
- Tempo: tempo = 11 gives 2-cycle beats (note 0 high for 2 cycles). Changing tempo mid-note does not alter that note's length.
- Pause: pause pulse 3 cycles into note 0, held paused 10 cycles, then second pause:
  - tone_enable is 0 while paused;
  - the total audible time of note 0 is still 8 cycles.
- Stop and reset:
  - stop and pause in the same cycle mid-note: done pulses, state IDLE, tone_enable = 0.
  - rst asserted mid-PLAY: all outputs go to 0 immediately (asynchronous) and state is IDLE on release.
